// File: rtl/bp_fe_bp_cfg_pkg.sv
// Shared types and elaboration helpers for the configurable two-level
// branch direction predictors.
package bp_fe_bp_cfg_pkg;

    typedef enum logic [1:0] {
        bp_mode_local_e  = 2'd0,
        bp_mode_global_e = 2'd1,
        bp_mode_gshare_e = 2'd2
    } bp_mode_e;

    // gshare folds the history into the branch index; the other modes append it.
    function automatic int pht_idx_width(bp_mode_e mode, int idx_w, int n_hist);
        return (mode == bp_mode_gshare_e) ? idx_w : idx_w + n_hist;
    endfunction

    // Weakly-not-taken: the largest value whose MSB is still clear.
    function automatic int cnt_reset_val(int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/bp_fe_bp_pht.sv
// Pattern history table: array of saturating counters with one registered
// read port and one saturating update port.
module bp_fe_bp_pht
    import bp_fe_bp_cfg_pkg::*;
#(
    parameter int idx_width_p = 4,
    parameter int cnt_width_p = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   r_v_i,
    input  logic [idx_width_p-1:0] r_idx_i,
    input  logic                   w_v_i,
    input  logic [idx_width_p-1:0] w_idx_i,
    input  logic                   taken_i,
    output logic                   predict_v_o,
    output logic                   predict_o
);

    localparam int                     entries_lp = 1 << idx_width_p;
    localparam logic [cnt_width_p-1:0] cnt_rst_lp = cnt_width_p'(cnt_reset_val(cnt_width_p));
    localparam logic [cnt_width_p-1:0] cnt_max_lp = '1;
    localparam logic [cnt_width_p-1:0] cnt_one_lp = cnt_width_p'(1);

    logic [cnt_width_p-1:0] cnt_q [entries_lp];
    logic [cnt_width_p-1:0] w_cnt;

    assign w_cnt = cnt_q[w_idx_i];

    // NOTE: the table is reset as flops rather than a RAM because an
    // asserted reset must return every counter to weak-NT at once.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < entries_lp; i++) begin
                cnt_q[i] <= cnt_rst_lp;
            end
        end else if (w_v_i) begin
            if (taken_i && (w_cnt != cnt_max_lp)) begin
                cnt_q[w_idx_i] <= w_cnt + cnt_one_lp;
            end else if (!taken_i && (w_cnt != '0)) begin
                cnt_q[w_idx_i] <= w_cnt - cnt_one_lp;
            end
        end
    end

    // NOTE: non-blocking updates mean a same-cycle read samples the counter
    // as it was before this edge's update, giving read-before-write for free.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            predict_v_o <= 1'b0;
            predict_o   <= 1'b0;
        end else begin
            predict_v_o <= r_v_i;
            if (r_v_i) begin
                predict_o <= cnt_q[r_idx_i][cnt_width_p-1];
            end
        end
    end

endmodule

// File: rtl/bp_fe_bp_two_level_cfg.sv
// Configurable two-level direction predictor: local, global or gshare
// history selects a counter in a shared pattern history table.
module bp_fe_bp_two_level_cfg
    import bp_fe_bp_cfg_pkg::*;
#(
    parameter int bht_idx_width_p   = 2,
    parameter int bp_cnt_sat_bits_p = 2,
    parameter int bp_n_hist         = 2,
    parameter int mode_p            = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic                       taken_i,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       predict_v_o,
    output logic                       predict_o
);

    localparam bp_mode_e mode_lp   = bp_mode_e'(mode_p[1:0]);
    localparam int       pht_w_lp  = pht_idx_width(mode_lp, bht_idx_width_p, bp_n_hist);
    localparam int       hist_n_lp = (mode_lp == bp_mode_local_e) ? (1 << bht_idx_width_p) : 1;

    if (mode_p < 0 || mode_p > 2) begin : g_bad_mode
        $error("bp_fe_bp_two_level_cfg: mode_p must be 0, 1 or 2");
    end
    if (mode_p == 2 && bp_n_hist > bht_idx_width_p) begin : g_bad_gshare
        $error("bp_fe_bp_two_level_cfg: gshare needs bp_n_hist <= bht_idx_width_p");
    end
    if (bp_n_hist < 1 || bp_cnt_sat_bits_p < 1) begin : g_bad_width
        $error("bp_fe_bp_two_level_cfg: history and counter widths must be >= 1");
    end

    logic [bp_n_hist-1:0] hist_q [hist_n_lp];
    logic [bp_n_hist-1:0] r_hist;
    logic [bp_n_hist-1:0] w_hist;
    logic [bp_n_hist-1:0] w_hist_next;
    logic [pht_w_lp-1:0]  r_pht_idx;
    logic [pht_w_lp-1:0]  w_pht_idx;

    if (bp_n_hist == 1) begin : g_shift_1
        assign w_hist_next = taken_i;
    end else begin : g_shift_n
        assign w_hist_next = {w_hist[bp_n_hist-2:0], taken_i};
    end

    if (mode_lp == bp_mode_local_e) begin : g_local_hist
        assign r_hist = hist_q[idx_r_i];
        assign w_hist = hist_q[idx_w_i];

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                for (int i = 0; i < hist_n_lp; i++) begin
                    hist_q[i] <= '0;
                end
            end else if (w_v_i) begin
                hist_q[idx_w_i] <= w_hist_next;
            end
        end
    end else begin : g_global_hist
        assign r_hist = hist_q[0];
        assign w_hist = hist_q[0];

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                hist_q[0] <= '0;
            end else if (w_v_i) begin
                hist_q[0] <= w_hist_next;
            end
        end
    end

    // The update index is built from the pre-update history on purpose.
    if (mode_lp == bp_mode_gshare_e) begin : g_idx_gshare
        assign r_pht_idx = idx_r_i ^ bht_idx_width_p'(r_hist);
        assign w_pht_idx = idx_w_i ^ bht_idx_width_p'(w_hist);
    end else begin : g_idx_concat
        assign r_pht_idx = {idx_r_i, r_hist};
        assign w_pht_idx = {idx_w_i, w_hist};
    end

    bp_fe_bp_pht #(
        .idx_width_p (pht_w_lp),
        .cnt_width_p (bp_cnt_sat_bits_p)
    ) u_pht (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .r_v_i       (r_v_i),
        .r_idx_i     (r_pht_idx),
        .w_v_i       (w_v_i),
        .w_idx_i     (w_pht_idx),
        .taken_i     (taken_i),
        .predict_v_o (predict_v_o),
        .predict_o   (predict_o)
    );

endmodule

// File: tb/tb_bp_fe_bp_two_level_cfg.sv
// Bench for bp_fe_bp_two_level_cfg: four configurations share one stimulus
// stream and are checked against directed values and a behavioural model.
module tb_bp_fe_bp_two_level_cfg;

    // Config 0: local defaults; 1: local, 1-bit history; 2: gshare; 3: global.
    localparam int n_cfg = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       w_v = 1'b0;
    logic [1:0] idx_w = '0;
    logic       taken = 1'b0;
    logic       r_v = 1'b0;
    logic [1:0] idx_r = '0;
    logic [3:0] pv;
    logic [3:0] pp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bp_fe_bp_two_level_cfg #(.bht_idx_width_p(2), .bp_cnt_sat_bits_p(2), .bp_n_hist(2), .mode_p(0)) u_loc (
        .clk_i(clk), .reset_n_i(reset_n), .w_v_i(w_v), .idx_w_i(idx_w), .taken_i(taken),
        .r_v_i(r_v), .idx_r_i(idx_r), .predict_v_o(pv[0]), .predict_o(pp[0]));
    bp_fe_bp_two_level_cfg #(.bht_idx_width_p(2), .bp_cnt_sat_bits_p(2), .bp_n_hist(1), .mode_p(0)) u_sat (
        .clk_i(clk), .reset_n_i(reset_n), .w_v_i(w_v), .idx_w_i(idx_w), .taken_i(taken),
        .r_v_i(r_v), .idx_r_i(idx_r), .predict_v_o(pv[1]), .predict_o(pp[1]));
    bp_fe_bp_two_level_cfg #(.bht_idx_width_p(2), .bp_cnt_sat_bits_p(2), .bp_n_hist(2), .mode_p(2)) u_gsh (
        .clk_i(clk), .reset_n_i(reset_n), .w_v_i(w_v), .idx_w_i(idx_w), .taken_i(taken),
        .r_v_i(r_v), .idx_r_i(idx_r), .predict_v_o(pv[2]), .predict_o(pp[2]));
    bp_fe_bp_two_level_cfg #(.bht_idx_width_p(2), .bp_cnt_sat_bits_p(2), .bp_n_hist(2), .mode_p(1)) u_glb (
        .clk_i(clk), .reset_n_i(reset_n), .w_v_i(w_v), .idx_w_i(idx_w), .taken_i(taken),
        .r_v_i(r_v), .idx_r_i(idx_r), .predict_v_o(pv[3]), .predict_o(pp[3]));

    // Reference model: counters as integers, histories as integers.
    int nh [n_cfg] = '{2, 1, 2, 2};
    int md [n_cfg] = '{0, 0, 2, 1};
    int cnt  [n_cfg][64];
    int hist [n_cfg][4];
    bit exp_v [n_cfg];
    bit exp_p [n_cfg];

    function automatic int pidx(int c, int idx);
        int h;
        h = (md[c] == 0) ? hist[c][idx] : hist[c][0];
        if (md[c] == 2) return idx ^ h;
        return idx * (1 << nh[c]) + h;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < n_cfg; c++) begin
            for (int e = 0; e < 64; e++) cnt[c][e] = 1;
            for (int h = 0; h < 4; h++) hist[c][h] = 0;
            exp_v[c] = 1'b0;
            exp_p[c] = 1'b0;
        end
    endtask

    task automatic model_step(bit wv, int iw, bit tk, bit rv, int ir);
        int p;
        int hi;
        for (int c = 0; c < n_cfg; c++) begin
            if (rv) exp_p[c] = (cnt[c][pidx(c, ir)] >= 2);
            exp_v[c] = rv;
        end
        if (wv) begin
            for (int c = 0; c < n_cfg; c++) begin
                p  = pidx(c, iw);
                hi = (md[c] == 0) ? iw : 0;
                if (tk) cnt[c][p] = (cnt[c][p] == 3) ? 3 : cnt[c][p] + 1;
                else    cnt[c][p] = (cnt[c][p] == 0) ? 0 : cnt[c][p] - 1;
                hist[c][hi] = ((hist[c][hi] << 1) | int'(tk)) & ((1 << nh[c]) - 1);
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model, returns 1 time unit past the edge.
    task automatic cycle(bit wv, int iw, bit tk, bit rv, int ir);
        w_v   = wv;
        idx_w = 2'(iw);
        taken = tk;
        r_v   = rv;
        idx_r = 2'(ir);
        model_step(wv, iw, tk, rv, ir);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        w_v = 1'b0; taken = 1'b0; r_v = 1'b0; idx_w = '0; idx_r = '0;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        #2;
        for (int c = 0; c < n_cfg; c++) begin
            n_tests++;
            if (pv[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pv cfg%0d: got %b want 0", c, pv[c]);
            end
            n_tests++;
            if (pp[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pp cfg%0d: got %b want 0", c, pp[c]);
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(0, 0, 0, 1, 1);
        n_tests++;
        if (pv[0] !== 1'b1 || pp[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL first_read: got v=%b p=%b want v=1 p=0", pv[0], pp[0]);
        end
    endtask

    task automatic test_local_train();
        do_reset();
        cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1);
        n_tests++;
        if (pp[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL local_after_one: got %b want 0", pp[0]);
        end
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1);
        n_tests++;
        if (pv[0] !== 1'b1 || pp[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL local_after_four: got v=%b p=%b want v=1 p=1", pv[0], pp[0]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        n_tests++;
        if (pp[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_high: got %b want 1", pp[1]);
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        n_tests++;
        if (pp[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_low: got %b want 0", pp[1]);
        end
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        n_tests++;
        if (pp[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_floor: got %b want 0", pp[1]);
        end
    endtask

    task automatic test_gshare();
        do_reset();
        cycle(1, 2, 1, 0, 0);
        cycle(0, 0, 0, 1, 3);
        n_tests++;
        if (pp[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL gshare_idx3: got %b want 1", pp[2]);
        end
        cycle(0, 0, 0, 1, 2);
        n_tests++;
        if (pp[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL gshare_idx2: got %b want 0", pp[2]);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        cycle(1, 1, 1, 1, 1);
        n_tests++;
        if (pv[0] !== 1'b1 || pp[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_rbw: got v=%b p=%b want v=1 p=0", pv[0], pp[0]);
        end
        cycle(0, 0, 0, 1, 1);
        n_tests++;
        if (pp[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_next: got %b want 0", pp[0]);
        end
        // gshare: GHR is now 01, so idx 0 lands on the entry trained above.
        cycle(0, 0, 0, 1, 0);
        n_tests++;
        if (pp[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_gshare_visible: got %b want 1", pp[2]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1);
        n_tests++;
        if (pv[0] !== 1'b1 || pp[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_trained: got v=%b p=%b want v=1 p=1", pv[0], pp[0]);
        end
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (pv[0] !== 1'b0 || pp[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got v=%b p=%b want v=0 p=0", pv[0], pp[0]);
        end
        reset_n = 1'b1;
        cycle(0, 0, 0, 1, 1);
        n_tests++;
        if (pv[0] !== 1'b1 || pp[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after_release: got v=%b p=%b want v=1 p=0", pv[0], pp[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
            for (int c = 0; c < n_cfg; c++) begin
                n_tests++;
                if (pv[c] !== exp_v[c] || pp[c] !== exp_p[c]) begin
                    n_fail++;
                    $display("FAIL random cyc%0d cfg%0d: got v=%b p=%b want v=%b p=%b",
                             n, c, pv[c], pp[c], exp_v[c], exp_p[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_local_train();
        test_saturation();
        test_gshare();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_fe_bp_two_level_cfg.md
# bp_fe_bp_two_level_cfg

Configurable two-level branch direction predictor for the front end, generalising the two-level local predictor. It supports three indexing modes: per-entry local history, a single global history register, and gshare (index XOR global history). Counter width and history length are parametrised. Prediction reads are registered with an explicit valid. Resolved-branch updates train both the history and the pattern tables in one cycle.

## Interface
- bht_idx_width_p, 2: width of branch index (BHT has 2^bht_idx_width_p entries).
- bp_cnt_sat_bits_p, 2: saturating counter width, ≥1.
- bp_n_hist, 2: history length in bits, ≥1.
- mode_p, 0: 0 = local, 1 = global, 2 = gshare. Gshare requires bp_n_hist ≤ bht_idx_width_p (elaboration error otherwise).
- clk_i  in  1  clock; all state on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- w_v_i  in  1  update valid.
- idx_w_i  in  bht_idx_width_p  index of resolved branch.
- taken_i  in  1  resolved direction (1 = taken).
- r_v_i  in  1  prediction request valid.
- idx_r_i  in  bht_idx_width_p  index to predict.
- predict_v_o  out  1  prediction valid; reset 0.
- predict_o  out  1  predicted direction; reset 0.

## Operation
- History:
  - local: one bp_n_hist-bit register per BHT entry.
  - global/gshare: one shared GHR.
  - All histories reset to 0.
- PHT index (width pht_w):
  - local/global: {idx, hist}, pht_w = bht_idx_width_p + bp_n_hist.
  - gshare: idx ^ zero-extended hist, pht_w = bht_idx_width_p.
- Counters reset to weakly-not-taken, 2^(bp_cnt_sat_bits_p-1)-1 (01 for 2 bits).
- Prediction = counter MSB.
- Update when w_v_i=1:
  - PHT index is formed from the pre-update history.
  - taken_i=1 increments the counter, saturating at all-ones.
  - taken_i=0 decrements the counter, saturating at 0.
  - The selected history shifts left with taken_i into the LSB; the MSB is dropped.
- No update when w_v_i=0.
- Read when r_v_i=1: the PHT index uses the history of idx_r_i (local) or the GHR.
- Read and write in the same cycle: the read sees the pre-update state (read-before-write) for any index combination. No forwarding.

## Timing
- Read latency 1: r_v_i at edge t gives predict_v_o/predict_o valid after edge t.
- predict_v_o = r_v_i delayed one cycle.
- predict_o holds its last value while predict_v_o=0.
- An update issued in cycle t is visible to reads issued in cycle t+1.
- Back-to-back updates every cycle to the same index are supported. Each update uses the history produced by the previous one.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronously): predict_v_o=0, predict_o=0, counters to weak-NT, histories to 0.
  - A request presented in the same cycle as reset deassertion is serviced normally.
- No backpressure: requests and updates are always accepted.

## Structure
- Package bp_fe_bp_cfg_pkg holds:
  - mode enum (bp_mode_local_e, bp_mode_global_e, bp_mode_gshare_e);
  - function pht_idx_width(mode, idx_w, n_hist);
  - function cnt_reset_val(bits).
- Sub-module bp_fe_bp_pht:
  - 2^pht_w counter array with async reset;
  - one registered read port and one saturating update port;
  - reused by later predictors.
- History register file and index formation live in the top.

## Test plan
- Local mode, defaults; after reset, r_v_i=1 with idx_r_i=1 → next cycle predict_v_o=1, predict_o=0.
- Local mode, four updates to idx 1 with taken=1, then read idx 1:
  - PHT entries {01,00}, {01,01} and {01,11} step 01→10; the fourth update steps {01,11} to 11;
  - history ends at 11;
  - → predict_o=1.
  - A read after only the first update (history 01, entry {01,01}=01) → predict_o=0.
- Saturation, local mode, bp_n_hist=1:
  - 5 taken updates to idx 0 → counter stays at 11.
  - Then 4 not-taken updates → counter at 00, prediction 0.
  - A further not-taken update leaves it at 00.
- Gshare mode (mode_p=2):
  - Update idx 2 with taken=1: GHR 00→01, pht[2] 01→10.
  - Then read idx 3 (3^1=2) → predict_o=1. Read idx 2 (2^1=3) → predict_o=0.
- Same-cycle read and write to idx 1, with counter at 01 and taken=1 → predict_o=0. A read issued in the following cycle uses the updated history and table.
- Reset asserted while predict_v_o=1 and after training → predict_v_o and predict_o drop to 0 within the same cycle. A subsequent read of the previously trained index returns 0.
